mult_fu: RTL and testbench

- Multiply functional unit wrapper between reservation-station issue and the CDB arbiter.
- Decodes RV32M multiply ops into sign controls and instantiates the existing pipelined multiplier.
- Tracks tag/op alongside the multiplier pipeline, selects the low or high product half, and buffers results in a credit-protected FIFO until the CDB grants.
- The multiplier cannot stall, so issue is throttled by credits rather than by back-pressure into the multiplier.

---
 rtl/mult_fu_pkg.sv | 29 ++
 rtl/mult.sv | 55 +++++
 rtl/mult_fu_result_fifo.sv | 50 +++++
 rtl/mult_fu.sv | 115 +++++++++++
 tb/tb_mult_fu.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_fu_pkg.sv
// Shared types and helpers for the multiply functional unit.
package mult_fu_pkg;

  typedef logic [1:0] mult_op_t;

  localparam mult_op_t MULT_OP_MUL    = 2'd0;
  localparam mult_op_t MULT_OP_MULH   = 2'd1;
  localparam mult_op_t MULT_OP_MULHSU = 2'd2;
  localparam mult_op_t MULT_OP_MULHU  = 2'd3;

  localparam int MULT_FU_XLEN  = 32;
  localparam int MULT_FU_TAG_W = 6;

  // Result buffer entry layout at default widths: tag sits above the value.
  typedef struct packed {
    logic [MULT_FU_TAG_W-1:0] tag;
    logic [MULT_FU_XLEN-1:0]  value;
  } mult_fu_entry_t;

  // sign[0] qualifies mcand (rs1), sign[1] qualifies mplier (rs2).
  function automatic logic [1:0] mult_sign(input mult_op_t op);
    case (op)
      MULT_OP_MUL, MULT_OP_MULH: mult_sign = 2'b11;
      MULT_OP_MULHSU:            mult_sign = 2'b01;
      default:                   mult_sign = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mult.sv
// Pipelined multiplier: each stage folds CHUNK bits of the multiplier into
// the running 2*XLEN-bit product. Cannot stall. Only the done pipe is reset.
module mult #(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   mcand,
  input  logic [XLEN-1:0]   mplier,
  input  logic [1:0]        sign,
  input  logic              start,
  output logic [2*XLEN-1:0] product,
  output logic              done
);

  localparam int W     = 2 * XLEN;
  localparam int CHUNK = W / NUM_STAGE;

  logic [W-1:0] prod_in [NUM_STAGE];
  logic [W-1:0] a_in    [NUM_STAGE];
  logic [W-1:0] b_in    [NUM_STAGE];
  logic [W-1:0] prod_r  [NUM_STAGE];
  logic [W-1:0] a_r     [NUM_STAGE];
  logic [W-1:0] b_r     [NUM_STAGE];
  logic [NUM_STAGE-1:0] done_r;

  assign prod_in[0] = '0;
  assign a_in[0]    = sign[0] ? {{XLEN{mcand[XLEN-1]}}, mcand}   : {{XLEN{1'b0}}, mcand};
  assign b_in[0]    = sign[1] ? {{XLEN{mplier[XLEN-1]}}, mplier} : {{XLEN{1'b0}}, mplier};

  for (genvar s = 0; s < NUM_STAGE; s++) begin : g_stage
    if (s > 0) begin : g_link
      assign prod_in[s] = prod_r[s-1];
      assign a_in[s]    = a_r[s-1];
      assign b_in[s]    = b_r[s-1];
    end
    // Accumulate this stage's partial product and shift operands for the next.
    always_ff @(posedge clock) begin
      prod_r[s] <= prod_in[s] + a_in[s] * {{(W-CHUNK){1'b0}}, b_in[s][CHUNK-1:0]};
      a_r[s]    <= a_in[s] << CHUNK;
      b_r[s]    <= b_in[s] >> CHUNK;
    end
  end

  // Done tracks start through the pipe.
  always_ff @(posedge clock) begin
    if (reset) done_r <= '0;
    else       done_r <= (done_r << 1) | NUM_STAGE'(start);
  end

  assign product = prod_r[NUM_STAGE-1];
  assign done    = done_r[NUM_STAGE-1];

endmodule

// File: rtl/mult_fu_result_fifo.sv
// Result buffer between the multiplier and the CDB. Overflow is prevented
// upstream by credits, so push is accepted unconditionally.
module mult_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[head];

  // Pointer and count bookkeeping; flush empties the buffer.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)   tail <= tail + PTR_W'(1);
      if (do_pop) head <= head + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are qualified by count so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/mult_fu.sv
// Multiply functional unit: decodes RV32M ops, runs the pipelined multiplier,
// carries tag/op alongside it and buffers results until the CDB grants.
//
// Handshakes: an op transfers when issue_valid && issue_ready (and no flush);
// a result transfers when cdb_valid && cdb_grant. issue_ready depends only on
// registered credit state, and cdb_tag/cdb_value hold while !cdb_grant.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGE  = 4,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [XLEN-1:0]  issue_rs1,
  input  logic [XLEN-1:0]  issue_rs2,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             flush,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_value,
  output logic             busy
);

  localparam int OCC_W   = $clog2(FIFO_DEPTH+1);
  localparam int ENTRY_W = TAG_W + XLEN;

  logic [OCC_W-1:0]     occ;
  logic                 accept;
  logic                 pop;
  logic [NUM_STAGE-1:0] side_valid;
  logic [TAG_W-1:0]     side_tag [NUM_STAGE];
  mult_op_t             side_op  [NUM_STAGE];
  logic [2*XLEN-1:0]    product;
  logic [XLEN-1:0]      result;
  logic [ENTRY_W-1:0]   head_entry;
  logic [OCC_W-1:0]     fifo_count;

  assign issue_ready = (occ < OCC_W'(FIFO_DEPTH));
  assign accept      = issue_valid && issue_ready && !flush;
  assign cdb_valid   = (fifo_count != '0);
  assign pop         = cdb_valid && cdb_grant;
  assign busy        = (occ != '0);

  // Credits: one per op accepted and not yet retired to the CDB.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      occ <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Side-pipeline valids; these alone decide which products are real.
  always_ff @(posedge clock) begin
    if (!reset || flush) side_valid <= '0;
    else                 side_valid <= (side_valid << 1) | NUM_STAGE'(accept);
  end

  // Side-pipeline tag/op payload shifting in lockstep with the multiplier.
  always_ff @(posedge clock) begin
    side_tag[0] <= issue_tag;
    side_op[0]  <= issue_op;
    for (int s = 1; s < NUM_STAGE; s++) begin
      side_tag[s] <= side_tag[s-1];
      side_op[s]  <= side_op[s-1];
    end
  end

  mult #(
    .XLEN      (XLEN),
    .NUM_STAGE (NUM_STAGE)
  ) u_mult (
    .clock   (clock),
    .reset   (~reset),
    .mcand   (issue_rs1),
    .mplier  (issue_rs2),
    .sign    (mult_sign(issue_op)),
    .start   (accept),
    .product (product),
    .done    ()
  );

  assign result = (side_op[NUM_STAGE-1] == MULT_OP_MUL) ? product[XLEN-1:0]
                                                        : product[2*XLEN-1:XLEN];

  mult_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (side_valid[NUM_STAGE-1]),
    .push_data ({side_tag[NUM_STAGE-1], result}),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count)
  );

  // Head fields are forced to zero when empty so stale storage never shows.
  assign cdb_tag   = cdb_valid ? head_entry[ENTRY_W-1:XLEN] : '0;
  assign cdb_value = cdb_valid ? head_entry[XLEN-1:0]       : '0;

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: drivers push expected {tag,value} entries,
// a negedge monitor pops and compares whenever the CDB accepts a result.
module tb_mult_fu;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 6;
  localparam int ENTRY_W = TAG_W + XLEN;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  logic             clock;
  logic             reset;
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [XLEN-1:0]  issue_rs1;
  logic [XLEN-1:0]  issue_rs2;
  logic [TAG_W-1:0] issue_tag;
  logic             flush;
  logic             cdb_valid;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             busy;

  logic [ENTRY_W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  int pop_count    = 0;
  int first_pop    = 0;
  int last_pop     = 0;
  int max_occ      = 0;
  bit track_occ    = 0;

  mult_fu dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_tag   (issue_tag),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_grant   (cdb_grant),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .busy        (busy)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: compare every accepted CDB result against the scoreboard head
  always @(negedge clock) begin
    if (reset && cdb_valid && cdb_grant) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_result: got tag %0d value 0x%0h with nothing expected", cdb_tag, cdb_value);
      end else begin
        logic [ENTRY_W-1:0] e;
        e = exp_q.pop_front();
        check("cdb_tag", 64'(cdb_tag), 64'(e[ENTRY_W-1:XLEN]));
        check("cdb_value", 64'(cdb_value), 64'(e[XLEN-1:0]));
      end
      if (pop_count == 0) first_pop = cycle;
      last_pop = cycle;
      pop_count++;
    end
    if (track_occ && int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Driver: present one op, wait for ready, record expected result on accept
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_val);
    int guard;
    guard       = 0;
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_tag   = tag;
    @(negedge clock);
    while (!issue_ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (!issue_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: issue_ready stayed 0 for tag %0d", tag);
      @(posedge clock);
    end else begin
      @(posedge clock);
      exp_q.push_back({tag, exp_val});
    end
    #1;
    issue_valid = 1'b0;
  endtask

  // Cycles from the accept edge until cdb_valid is seen
  task automatic measure_latency(input string name, input int expected);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cdb_valid && n < 30);
    check(name, 64'(n), 64'(expected));
  endtask

  // Drain with grant held high until scoreboard and credits are empty
  task automatic drain(input string name);
    int guard;
    guard     = 0;
    cdb_grant = 1'b1;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int stale;
    reset       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_tag   = '0;
    flush       = 1'b0;
    cdb_grant   = 1'b0;
    tick(3);
    reset = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_value", 64'(cdb_value), 64'd0);
    tick(1);

    // MUL 7 x -3, tag 5, five cycles of latency
    cdb_grant = 1'b1;
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB);
    measure_latency("mul_latency", 5);
    drain("drain_mul");

    // High-half ops back to back
    issue(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 6'd1, 32'hFFFF_FFFF);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 6'd2, 32'hFFFF_FFFF);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 6'd3, 32'h0000_0001);
    drain("drain_high");

    // Credit exhaustion with grant held low
    cdb_grant = 1'b0;
    for (int i = 0; i < 8; i++)
      issue(OP_MUL, 32'(i + 1), 32'd3, 6'(10 + i), 32'((i + 1) * 3));
    @(negedge clock);
    check("ready_full", 64'(issue_ready), 64'd0);
    check("busy_full", 64'(busy), 64'd1);
    tick(6);
    @(negedge clock);
    check("ready_still_full", 64'(issue_ready), 64'd0);
    @(posedge clock);
    #1;
    cdb_grant = 1'b1;
    @(posedge clock);
    #1;
    cdb_grant = 1'b0;
    @(negedge clock);
    check("ready_after_grant", 64'(issue_ready), 64'd1);
    check("queue_after_grant", 64'(exp_q.size()), 64'd7);
    tick(1);
    drain("drain_full");

    // Continuous issue with continuous grant
    pop_count = 0;
    max_occ   = 0;
    track_occ = 1'b1;
    cdb_grant = 1'b1;
    for (int i = 0; i < 20; i++)
      issue(OP_MUL, 32'(i + 2), 32'(i + 5), 6'(20 + i), 32'((i + 2) * (i + 5)));
    drain("drain_stream");
    track_occ = 1'b0;
    check("stream_count", 64'(pop_count), 64'd20);
    check("stream_rate", 64'(last_pop - first_pop), 64'd19);
    check("stream_max_occ_ok", 64'(max_occ <= 5), 64'd1);

    // Flush with two buffered and three in flight
    cdb_grant = 1'b0;
    issue(OP_MUL, 32'd2, 32'd2, 6'd40, 32'd4);
    issue(OP_MUL, 32'd3, 32'd2, 6'd41, 32'd6);
    tick(6);
    issue(OP_MUL, 32'd4, 32'd2, 6'd42, 32'd8);
    issue(OP_MUL, 32'd5, 32'd2, 6'd43, 32'd10);
    issue(OP_MUL, 32'd6, 32'd2, 6'd44, 32'd12);
    tick(1);
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_op    = OP_MUL;
    issue_tag   = 6'd45;
    exp_q.delete();
    @(posedge clock);
    #1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    @(negedge clock);
    check("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_occ", 64'(dut.occ), 64'd0);
    check("flush_ready", 64'(issue_ready), 64'd1);
    cdb_grant = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clock);
      if (cdb_valid) stale++;
    end
    check("flush_no_stale", 64'(stale), 64'd0);
    @(posedge clock);
    #1;

    // Reset mid-stream with a result waiting
    cdb_grant = 1'b0;
    issue(OP_MUL, 32'd3, 32'd3, 6'd50, 32'd9);
    issue(OP_MUL, 32'd4, 32'd4, 6'd51, 32'd16);
    tick(5);
    @(negedge clock);
    check("pre_reset_valid", 64'(cdb_valid), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("mid_rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("mid_rst_cdb_value", 64'(cdb_value), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(issue_ready), 64'd1);
    tick(1);
    cdb_grant = 1'b1;
    issue(OP_MUL, 32'd6, 32'd7, 6'd9, 32'd42);
    measure_latency("post_rst_latency", 5);
    drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
